// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one shared memory port,
// one transaction in flight, with a starvation guard that eventually lets fetch win.
//
// state | meaning
// IDLE  | no transaction; grant the winner combinationally
// REQ   | mem_req_* presented from the captured request, waiting for mem_req_rdy
// WAIT  | request taken by memory, waiting for mem_resp_vld
// ERR   | one-cycle error response for a misaligned/illegal ls request
module mem_port_arbiter #(
  parameter int N_BITS     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_vld,
  input  logic [N_BITS-1:0] if_req_addr,
  output logic              if_req_rdy,
  output logic              if_resp_vld,
  output logic [N_BITS-1:0] if_resp_data,
  input  logic [3:0]        ls_req,
  input  logic [N_BITS-1:0] ls_req_addr,
  input  logic [N_BITS-1:0] ls_req_wdata,
  output logic              ls_req_rdy,
  output logic              ls_resp_vld,
  output logic [N_BITS-1:0] ls_resp_data,
  output logic              ls_resp_err,
  output logic              mem_req_vld,
  output logic              mem_req_mtype,
  output logic [1:0]        mem_req_len,
  output logic [N_BITS-1:0] mem_req_addr,
  output logic [N_BITS-1:0] mem_req_wdata,
  input  logic              mem_req_rdy,
  input  logic              mem_resp_vld,
  input  logic [N_BITS-1:0] mem_resp_data
);

  localparam int CW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_ERR} state_t;

  state_t            state;
  logic [CW-1:0]     starve_cnt;
  logic              owner_ls;
  logic              r_mtype;
  logic [1:0]        r_len;
  logic [N_BITS-1:0] r_addr;
  logic [N_BITS-1:0] r_wdata;

  logic       ls_vld;
  logic       ls_mtype;
  logic [1:0] ls_len;
  logic       ls_bad;
  logic       fetch_win;
  logic       ls_win;
  logic       in_idle;
  logic       in_req;
  logic       in_err;
  logic       resp_fire;

  assign ls_vld   = ls_req[3];
  assign ls_mtype = ls_req[2];
  assign ls_len   = ls_req[1:0];

  assign ls_bad = (ls_len == 2'b11) ||
                  ((ls_len == 2'b01) && ls_req_addr[0]) ||
                  ((ls_len == 2'b10) && (ls_req_addr[1:0] != 2'b00));

  // ls normally wins a tie; fetch takes over once it has lost STARVE_MAX times in a row
  assign fetch_win = if_req_vld && (!ls_vld || (starve_cnt == STARVE_LIM));
  assign ls_win    = ls_vld && !fetch_win;

  // Every output is forced low while reset is asserted, even mid-transaction
  assign in_idle   = rst_n && (state == S_IDLE);
  assign in_req    = rst_n && (state == S_REQ);
  assign in_err    = rst_n && (state == S_ERR);
  assign resp_fire = rst_n && (state == S_WAIT) && mem_resp_vld;

  assign if_req_rdy = in_idle && fetch_win;
  assign ls_req_rdy = in_idle && ls_win;

  assign mem_req_vld   = in_req;
  assign mem_req_mtype = in_req && r_mtype;
  assign mem_req_len   = in_req ? r_len   : 2'b00;
  assign mem_req_addr  = in_req ? r_addr  : '0;
  assign mem_req_wdata = in_req ? r_wdata : '0;

  assign if_resp_vld  = resp_fire && !owner_ls;
  assign if_resp_data = if_resp_vld ? mem_resp_data : '0;
  assign ls_resp_vld  = (resp_fire && owner_ls) || in_err;
  assign ls_resp_data = (resp_fire && owner_ls) ? mem_resp_data : '0;
  assign ls_resp_err  = in_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      starve_cnt <= '0;
      owner_ls   <= 1'b0;
      r_mtype    <= 1'b0;
      r_len      <= 2'b00;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (fetch_win) begin
            owner_ls   <= 1'b0;
            r_mtype    <= 1'b0;
            r_len      <= 2'b10;
            r_addr     <= if_req_addr;
            r_wdata    <= '0;
            starve_cnt <= '0;
            state      <= S_REQ;
          end else if (ls_win) begin
            owner_ls <= 1'b1;
            r_mtype  <= ls_mtype;
            r_len    <= ls_len;
            r_addr   <= ls_req_addr;
            r_wdata  <= ls_req_wdata;
            if (if_req_vld && (starve_cnt < STARVE_LIM))
              starve_cnt <= starve_cnt + CW'(1);
            state <= ls_bad ? S_ERR : S_REQ;
          end
        end
        S_REQ:   if (mem_req_rdy) state <= S_WAIT;
        S_WAIT:  if (mem_resp_vld) state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter: responses are checked against a queue of
// expected results pushed when each request is driven.
module tb_mem_port_arbiter;

  localparam int NB = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req_vld;
  logic [NB-1:0] if_req_addr;
  logic          if_req_rdy;
  logic          if_resp_vld;
  logic [NB-1:0] if_resp_data;
  logic [3:0]    ls_req;
  logic [NB-1:0] ls_req_addr;
  logic [NB-1:0] ls_req_wdata;
  logic          ls_req_rdy;
  logic          ls_resp_vld;
  logic [NB-1:0] ls_resp_data;
  logic          ls_resp_err;
  logic          mem_req_vld;
  logic          mem_req_mtype;
  logic [1:0]    mem_req_len;
  logic [NB-1:0] mem_req_addr;
  logic [NB-1:0] mem_req_wdata;
  logic          mem_req_rdy;
  logic          mem_resp_vld;
  logic [NB-1:0] mem_resp_data;

  mem_port_arbiter #(.N_BITS(NB), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_vld(if_req_vld), .if_req_addr(if_req_addr), .if_req_rdy(if_req_rdy),
    .if_resp_vld(if_resp_vld), .if_resp_data(if_resp_data),
    .ls_req(ls_req), .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata),
    .ls_req_rdy(ls_req_rdy), .ls_resp_vld(ls_resp_vld), .ls_resp_data(ls_resp_data),
    .ls_resp_err(ls_resp_err),
    .mem_req_vld(mem_req_vld), .mem_req_mtype(mem_req_mtype), .mem_req_len(mem_req_len),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_req_rdy(mem_req_rdy), .mem_resp_vld(mem_resp_vld), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic          is_ls;
    logic [NB-1:0] data;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  logic [NB-1:0] seen_addr;
  logic          seen_mtype;
  logic [1:0]    seen_len;
  logic          seen_ok;

  task automatic push_exp(input logic is_ls, input logic [NB-1:0] data, input logic err);
    exp_t e;
    e.is_ls = is_ls;
    e.data  = data;
    e.err   = err;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every response pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (if_resp_vld) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL if_resp_unexpected: got data=%h, required no response", if_resp_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.is_ls !== 1'b0 || if_resp_data !== mon_e.data) begin
          failures++;
          $display("FAIL if_resp: got if side data=%h, required is_ls=%b data=%h",
                   if_resp_data, mon_e.is_ls, mon_e.data);
        end
      end
    end
    if (ls_resp_vld) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL ls_resp_unexpected: got data=%h err=%b, required no response",
                 ls_resp_data, ls_resp_err);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.is_ls !== 1'b1 || ls_resp_data !== mon_e.data || ls_resp_err !== mon_e.err) begin
          failures++;
          $display("FAIL ls_resp: got ls side data=%h err=%b, required is_ls=%b data=%h err=%b",
                   ls_resp_data, ls_resp_err, mon_e.is_ls, mon_e.data, mon_e.err);
        end
      end
    end
  end

  // Memory side with rdy already high: accept, then answer in the first WAIT cycle
  task automatic mem_serve(input logic [NB-1:0] data);
    seen_ok = 1'b0;
    for (int i = 0; i < 20 && !seen_ok; i++) begin
      @(negedge clk);
      if (mem_req_vld) begin
        seen_ok    = 1'b1;
        seen_addr  = mem_req_addr;
        seen_mtype = mem_req_mtype;
        seen_len   = mem_req_len;
      end
    end
    checks++;
    if (!seen_ok) begin
      failures++;
      $display("FAIL mem_req_timeout: mem_req_vld=0 for 20 cycles, required 1");
      return;
    end
    @(posedge clk); #1;
    mem_resp_vld  = 1'b1;
    mem_resp_data = data;
    @(posedge clk); #1;
    mem_resp_vld  = 1'b0;
    mem_resp_data = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if_req_vld = 1'b1; if_req_addr = 32'h40;
    ls_req = 4'b1010; ls_req_addr = 32'h80; ls_req_wdata = 32'h1;
    mem_req_rdy = 1'b1; mem_resp_vld = 1'b1; mem_resp_data = 32'hFFFF_FFFF;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ((|{if_req_rdy, ls_req_rdy, if_resp_vld, ls_resp_vld, ls_resp_err, mem_req_vld,
             mem_req_mtype, mem_req_len, mem_req_addr, mem_req_wdata, if_resp_data,
             ls_resp_data}) !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs: rdy=%b/%b resp=%b/%b mem_vld=%b, required all outputs 0",
                 if_req_rdy, ls_req_rdy, if_resp_vld, ls_resp_vld, mem_req_vld);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1; if_req_vld = 1'b0; ls_req = 4'b0000;
    mem_resp_vld = 1'b0; mem_resp_data = '0;
    @(negedge clk);
    checks++;
    if ({if_req_rdy, ls_req_rdy, mem_req_vld} !== 3'b000) begin
      failures++;
      $display("FAIL idle_quiet: rdy/rdy/mem_vld=%b, required 000",
               {if_req_rdy, ls_req_rdy, mem_req_vld});
    end
    checks++;
    if (dut.starve_cnt !== 0) begin
      failures++;
      $display("FAIL reset_starve: starve_cnt=%0d, required 0", dut.starve_cnt);
    end
  endtask

  task automatic test_fetch_single();
    @(posedge clk); #1;
    push_exp(1'b0, 32'hDEAD_BEEF, 1'b0);
    if_req_vld = 1'b1; if_req_addr = 32'h100;
    @(negedge clk);
    checks++;
    if (if_req_rdy !== 1'b1) begin
      failures++;
      $display("FAIL fetch_rdy: if_req_rdy=%b, required 1", if_req_rdy);
    end
    @(posedge clk); #1;
    if_req_vld = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_req_vld, mem_req_mtype, mem_req_len, mem_req_addr, mem_req_wdata} !==
        {1'b1, 1'b0, 2'b10, 32'h100, 32'h0}) begin
      failures++;
      $display("FAIL fetch_mem_req: vld=%b mtype=%b len=%b addr=%h wdata=%h, required 1 0 10 00000100 0",
               mem_req_vld, mem_req_mtype, mem_req_len, mem_req_addr, mem_req_wdata);
    end
    @(posedge clk); #1;
    mem_resp_vld = 1'b1; mem_resp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if ({if_resp_vld, mem_req_vld} !== 2'b10) begin
      failures++;
      $display("FAIL fetch_resp_timing: if_resp_vld=%b mem_req_vld=%b, required 1 0",
               if_resp_vld, mem_req_vld);
    end
    @(posedge clk); #1;
    mem_resp_vld = 1'b0; mem_resp_data = '0;
  endtask

  task automatic test_starvation();
    logic [5:0] pat;
    logic       fw;
    logic [NB-1:0] d;
    pat = 6'b010000;  // ls x4, fetch on the 5th, ls again once the count is cleared
    @(posedge clk); #1;
    if_req_vld = 1'b1; if_req_addr = 32'h400;
    ls_req = 4'b1010; ls_req_addr = 32'h800; ls_req_wdata = '0;
    for (int i = 0; i < 6; i++) begin
      fw = pat[i];
      d  = fw ? (32'hF000_0000 + i) : (32'hA000_0000 + i);
      push_exp(!fw, d, 1'b0);
      @(negedge clk);
      checks++;
      if ({if_req_rdy, ls_req_rdy} !== {fw, !fw}) begin
        failures++;
        $display("FAIL starve_grant[%0d]: if_rdy=%b ls_rdy=%b, required %b %b",
                 i, if_req_rdy, ls_req_rdy, fw, !fw);
      end
      @(posedge clk); #1;
      if (i == 5) begin
        if_req_vld = 1'b0; ls_req = 4'b0000;
      end
      mem_serve(d);
      checks++;
      if (seen_addr !== (fw ? 32'h400 : 32'h800)) begin
        failures++;
        $display("FAIL starve_addr[%0d]: mem_req_addr=%h, required %h",
                 i, seen_addr, fw ? 32'h400 : 32'h800);
      end
      if (i == 3) begin
        checks++;
        if (dut.starve_cnt !== 4) begin
          failures++;
          $display("FAIL starve_cnt_sat: starve_cnt=%0d, required 4", dut.starve_cnt);
        end
      end
      if (i == 4) begin
        checks++;
        if (dut.starve_cnt !== 0) begin
          failures++;
          $display("FAIL starve_cnt_clr: starve_cnt=%0d, required 0", dut.starve_cnt);
        end
      end
    end
  endtask

  task automatic test_misaligned();
    logic [3:0]    ctl [3];
    logic [NB-1:0] adr [3];
    ctl[0] = 4'b1101; adr[0] = 32'h203;  // half write, odd address
    ctl[1] = 4'b1010; adr[1] = 32'h102;  // word read, not word aligned
    ctl[2] = 4'b1011; adr[2] = 32'h100;  // illegal length
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      push_exp(1'b1, '0, 1'b1);
      ls_req = ctl[i]; ls_req_addr = adr[i]; ls_req_wdata = 32'h1234;
      @(negedge clk);
      checks++;
      if (ls_req_rdy !== 1'b1) begin
        failures++;
        $display("FAIL err_rdy[%0d]: ls_req_rdy=%b, required 1", i, ls_req_rdy);
      end
      @(posedge clk); #1;
      ls_req = 4'b0000;
      @(negedge clk);
      checks++;
      if ({mem_req_vld, ls_resp_vld, ls_resp_err} !== 3'b011) begin
        failures++;
        $display("FAIL err_cycle[%0d]: mem_vld=%b resp_vld=%b err=%b, required 0 1 1",
                 i, mem_req_vld, ls_resp_vld, ls_resp_err);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({mem_req_vld, ls_resp_vld} !== 2'b00) begin
        failures++;
        $display("FAIL err_after[%0d]: mem_vld=%b resp_vld=%b, required 0 0",
                 i, mem_req_vld, ls_resp_vld);
      end
    end
  endtask

  task automatic test_byte_write_stall();
    @(posedge clk); #1;
    push_exp(1'b1, '0, 1'b0);
    mem_req_rdy = 1'b0;
    ls_req = 4'b1100; ls_req_addr = 32'h7; ls_req_wdata = 32'h55;
    @(negedge clk);
    checks++;
    if (ls_req_rdy !== 1'b1) begin
      failures++;
      $display("FAIL bw_rdy: ls_req_rdy=%b, required 1", ls_req_rdy);
    end
    @(posedge clk); #1;
    ls_req = 4'b0000; ls_req_wdata = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({mem_req_vld, mem_req_mtype, mem_req_len, mem_req_addr, mem_req_wdata} !==
          {1'b1, 1'b1, 2'b00, 32'h7, 32'h55}) begin
        failures++;
        $display("FAIL bw_stable[%0d]: vld=%b mtype=%b len=%b addr=%h wdata=%h, required 1 1 00 7 55",
                 k, mem_req_vld, mem_req_mtype, mem_req_len, mem_req_addr, mem_req_wdata);
      end
      @(posedge clk); #1;
      if (k == 2) mem_req_rdy = 1'b1;
    end
    mem_resp_vld = 1'b1; mem_resp_data = '0;
    @(negedge clk);
    checks++;
    if ({mem_req_vld, ls_resp_vld, ls_resp_err} !== 3'b010) begin
      failures++;
      $display("FAIL bw_ack: mem_vld=%b resp_vld=%b err=%b, required 0 1 0",
               mem_req_vld, ls_resp_vld, ls_resp_err);
    end
    @(posedge clk); #1;
    mem_resp_vld = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    if_req_vld = 1'b1; if_req_addr = 32'h300;
    @(posedge clk); #1;
    if_req_vld = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; if_req_vld = 1'b1;
    mem_resp_vld = 1'b1; mem_resp_data = 32'hBAD0_BAD0;
    @(negedge clk);
    checks++;
    if ((|{if_req_rdy, ls_req_rdy, if_resp_vld, ls_resp_vld, ls_resp_err, mem_req_vld,
           if_resp_data, ls_resp_data, mem_req_addr}) !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_outputs: rdy=%b/%b resp=%b/%b mem_vld=%b, required all 0",
               if_req_rdy, ls_req_rdy, if_resp_vld, ls_resp_vld, mem_req_vld);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; if_req_vld = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_resp_vld, ls_resp_vld, mem_req_vld} !== 3'b000) begin
      failures++;
      $display("FAIL rst_late_resp: if_resp=%b ls_resp=%b mem_vld=%b, required 000",
               if_resp_vld, ls_resp_vld, mem_req_vld);
    end
    @(posedge clk); #1;
    mem_resp_vld = 1'b0; mem_resp_data = '0;
    push_exp(1'b0, 32'h1234_5678, 1'b0);
    if_req_vld = 1'b1; if_req_addr = 32'h304;
    @(posedge clk); #1;
    if_req_vld = 1'b0;
    mem_serve(32'h1234_5678);
    checks++;
    if ({seen_mtype, seen_len, seen_addr} !== {1'b0, 2'b10, 32'h304}) begin
      failures++;
      $display("FAIL rst_next_fetch: mtype=%b len=%b addr=%h, required 0 10 00000304",
               seen_mtype, seen_len, seen_addr);
    end
  endtask

  task automatic test_resp_in_req();
    @(posedge clk); #1;
    push_exp(1'b0, 32'hCAFE_0001, 1'b0);
    mem_req_rdy = 1'b0;
    if_req_vld = 1'b1; if_req_addr = 32'h500;
    @(posedge clk); #1;
    if_req_vld = 1'b0;
    mem_resp_vld = 1'b1; mem_resp_data = 32'h0000_0BAD;
    @(negedge clk);
    checks++;
    if ({mem_req_vld, if_resp_vld} !== 2'b10) begin
      failures++;
      $display("FAIL req_early_resp: mem_vld=%b if_resp=%b, required 1 0", mem_req_vld, if_resp_vld);
    end
    @(posedge clk); #1;
    mem_resp_vld = 1'b0; mem_resp_data = '0; mem_req_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_req_vld, mem_req_addr} !== {1'b1, 32'h500}) begin
      failures++;
      $display("FAIL req_still: mem_vld=%b addr=%h, required 1 00000500", mem_req_vld, mem_req_addr);
    end
    @(posedge clk); #1;
    mem_resp_vld = 1'b1; mem_resp_data = 32'hCAFE_0001;
    @(negedge clk);
    checks++;
    if (if_resp_vld !== 1'b1) begin
      failures++;
      $display("FAIL req_late_resp: if_resp_vld=%b, required 1", if_resp_vld);
    end
    @(posedge clk); #1;
    mem_resp_vld = 1'b0; mem_resp_data = '0;
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    push_exp(1'b0, 32'h1111_2222, 1'b0);
    if_req_vld = 1'b1; if_req_addr = 32'h600;
    @(posedge clk); #1;
    if_req_vld = 1'b0;
    push_exp(1'b1, 32'h3333_4444, 1'b0);
    ls_req = 4'b1010; ls_req_addr = 32'h604;
    @(negedge clk);
    checks++;
    if ({ls_req_rdy, mem_req_vld, mem_req_addr} !== {1'b0, 1'b1, 32'h600}) begin
      failures++;
      $display("FAIL b2b_n1: ls_rdy=%b mem_vld=%b addr=%h, required 0 1 00000600",
               ls_req_rdy, mem_req_vld, mem_req_addr);
    end
    @(posedge clk); #1;
    mem_resp_vld = 1'b1; mem_resp_data = 32'h1111_2222;
    @(negedge clk);
    checks++;
    if (ls_req_rdy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_n2: ls_req_rdy=%b, required 0", ls_req_rdy);
    end
    @(posedge clk); #1;
    mem_resp_vld = 1'b0; mem_resp_data = '0;
    @(negedge clk);
    checks++;
    if (ls_req_rdy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_n3: ls_req_rdy=%b, required 1", ls_req_rdy);
    end
    @(posedge clk); #1;
    ls_req = 4'b0000;
    mem_serve(32'h3333_4444);
    checks++;
    if ({seen_mtype, seen_len, seen_addr} !== {1'b0, 2'b10, 32'h604}) begin
      failures++;
      $display("FAIL b2b_ls_req: mtype=%b len=%b addr=%h, required 0 10 00000604",
               seen_mtype, seen_len, seen_addr);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch_single();
    test_starvation();
    test_misaligned();
    test_byte_write_stall();
    test_reset_mid();
    test_resp_in_req();
    test_back_to_back();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
